ultrasound_clk_lock_sequencer: RTL and testbench
================================================

Name: ultrasound_clk_lock_sequencer

Overview:
- Consumer end of the ultrasound counter clock generator's control interface: drives the MMCM RST input and consumes its asynchronous LOCKED output.
- Runs on the free-running 25.6 MHz board clock, which also feeds the MMCM, so it never depends on the clock it supervises.
- Sequences MMCM reset, waits for lock with timeout and retry, and debounces lock before releasing the downstream ultrasound-domain reset.
- Detects loss of lock during operation and restarts the sequence.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronising locked_in; legal range 2..4.
- RST_CYCLES, 16: clk cycles mmcm_rst is held high per attempt; must be ≥ 1.
- LOCK_TIMEOUT, 65536: clk cycles to wait for lock before retrying; must be ≥ 2.
- STABLE_CYCLES, 1024: consecutive synchronised-high lock cycles required before release; must be ≥ 1.
- MAX_RETRY, 7: failed lock attempts before the fault state; must be ≥ 1.

Ports:
- clk  input  1  25.6 MHz free-running reference clock.
- rst_n  input  1  asynchronous active-low reset.
- locked_in  input  1  MMCM LOCKED, asynchronous to clk.
- mmcm_rst  output  1  to MMCM RST, active-high.
- clk_rst  output  1  active-high reset for ultrasound-domain logic; the downstream domain re-synchronises it.
- ready  output  1  high when the clock is locked and stable.
- fault  output  1  sticky; retries exhausted.
- retry_cnt  output  3  failed attempts in the current sequence.
- lock_loss_cnt  output  8  lock-loss events; present only with the optional feature.

Behaviour:
- Reset values while rst_n is low: state=RST_MMCM, mmcm_rst=1, clk_rst=1, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, all timers 0, synchroniser chain 0.
- locked_in passes through the SYNC_STAGES synchroniser; lk denotes the last stage. No raw use of locked_in anywhere.
- Single down/up timer, 17 bits wide, reloaded on every state entry.
- All outputs are registered, decoded from the next state, so they change in the same cycle as the state register.
- RST_MMCM: mmcm_rst=1, clk_rst=1.
  - Counts RST_CYCLES cycles, then → WAIT_LOCK.
  - Exit is on the cycle after the last count, so mmcm_rst is high for exactly RST_CYCLES cycles.
- WAIT_LOCK: mmcm_rst=0, clk_rst=1.
  - lk=1 → STABILIZE.
  - Timer reaching LOCK_TIMEOUT without lock → retry_cnt+1, then:
    - if the new retry_cnt == MAX_RETRY → FAULT;
    - otherwise → RST_MMCM.
  - lk rising on the timeout cycle: lock wins, → STABILIZE.
- STABILIZE: mmcm_rst=0, clk_rst=1.
  - Counts consecutive lk=1 cycles.
  - lk=0 at any point → WAIT_LOCK; the timeout timer restarts and retry_cnt is unchanged (glitch, not a failure).
  - Count reaching STABLE_CYCLES → RUN.
- RUN: ready=1, clk_rst=0, mmcm_rst=0, retry_cnt cleared to 0.
  - lk=0 for one cycle → LOST.
- LOST: for exactly one cycle ready=0, clk_rst=1, lock_loss_cnt increments (feature only), then → RST_MMCM.
- FAULT: terminal until rst_n is asserted.
  - fault=1, mmcm_rst=1 (MMCM held off), clk_rst=1, ready=0.
  - lk is ignored.
- ready falls on the same edge that clk_rst rises; clk_rst never deasserts unless ready rises on the same edge.
- rst_n asserted mid-sequence: immediate asynchronous return to reset values, including fault.
- rst_n deassertion is not internally synchronised; the top-level reset bridge guarantees it is synchronous to clk.

Optional Feature:
- Macro: ULTRASOUND_CLK_LOCK_LOSS_CNT_EN.
- Defined: lock_loss_cnt is an 8-bit counter incremented on each LOST entry.
  - Saturates at 255; no wrap.
  - Cleared only by rst_n.
- Undefined:
  - lock_loss_cnt is tied to 8'd0;
  - no counter flops are synthesised;
  - the port list is unchanged.

Test Plan:
- Normal bring-up: release rst_n, raise locked_in 100 cycles after mmcm_rst falls, keep it high → mmcm_rst high for exactly 16 cycles; ready rises exactly SYNC_STAGES+1024+1 cycles after locked_in rises (±1 for async sampling); clk_rst falls the same cycle.
- Lock glitch during STABILIZE: locked_in high 500 cycles, low 1 cycle, high again → ready delayed until 1024 fresh consecutive high cycles; retry_cnt=0; mmcm_rst stays 0.
- Timeout retry: locked_in held low, LOCK_TIMEOUT overridden to 64 → mmcm_rst re-pulses 16 cycles after each 64-cycle wait; retry_cnt steps 1..6; on the 7th failure fault=1, mmcm_rst=1, ready=0; later lock assertion is ignored.
- Lock loss in RUN (feature defined): drop locked_in for 3 cycles after ready → ready and clk_rst change on the same edge; one-cycle LOST; lock_loss_cnt=1; full RST_MMCM sequence follows; repeat 300 times → lock_loss_cnt saturates at 255.
- Feature undefined: the same lock-loss stimulus → lock_loss_cnt stays 0; sequencing is identical to the defined build.
- Async reset mid-STABILIZE and in FAULT: assert rst_n low between clock edges → all outputs reach reset values without a clock edge; fault clears.

Source files
------------

// File: rtl/ultrasound_clk_lock_sequencer.sv
// ultrasound_clk_lock_sequencer
//
// Controls the MMCM that generates the ultrasound counter clock. It runs on the
// free-running reference clock that also feeds the MMCM, so it never depends on
// the clock it supervises. The sequence is:
//   - pulse MMCM RST
//   - wait for LOCKED, with a timeout and a bounded number of retries
//   - require LOCKED to stay high for a debounce window
//   - release the ultrasound-domain reset
// A loss of lock while running restarts the whole sequence.
//
// Optional feature (macro ULTRASOUND_CLK_LOCK_LOSS_CNT_EN):
//   - Defined: lock_loss_cnt is a saturating 8-bit count of lock-loss events.
//   - Undefined: lock_loss_cnt is tied to zero and no counter flops exist.
//   The port list is the same in both builds.

module ultrasound_clk_lock_sequencer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked_in,
  output logic       mmcm_rst,
  output logic       clk_rst,
  output logic       ready,
  output logic       fault,
  output logic [2:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_chk_sync
    $error("SYNC_STAGES must be in 2..4");
  end
  if (RST_CYCLES < 1 || RST_CYCLES > 131072) begin : gen_chk_rst
    $error("RST_CYCLES must be in 1..131072");
  end
  if (LOCK_TIMEOUT < 2 || LOCK_TIMEOUT > 131072) begin : gen_chk_timeout
    $error("LOCK_TIMEOUT must be in 2..131072");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 131072) begin : gen_chk_stable
    $error("STABLE_CYCLES must be in 1..131072");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 7) begin : gen_chk_retry
    $error("MAX_RETRY must be in 1..7 (retry_cnt is 3 bits)");
  end

  // Terminal timer values. The timer counts from 0, so "last" is count-1.
  localparam logic [16:0] RstLast     = 17'(RST_CYCLES - 1);
  localparam logic [16:0] TimeoutLast = 17'(LOCK_TIMEOUT - 1);
  localparam logic [16:0] StableLast  = 17'(STABLE_CYCLES - 1);
  localparam logic [2:0]  RetryMax    = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    StRstMmcm   = 3'd0,
    StWaitLock  = 3'd1,
    StStabilize = 3'd2,
    StRun       = 3'd3,
    StLost      = 3'd4,
    StFault     = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [16:0] timer_q, timer_d;
  logic [2:0]  retry_q, retry_d;
  logic [2:0]  retry_inc;

  logic        mmcm_rst_q, mmcm_rst_d;
  logic        clk_rst_q, clk_rst_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;

  // ---------------------------------------------------------------------------
  // LOCKED synchroniser
  // locked_in is asynchronous to clk. Only the last stage (lk) is used.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;

  // Shift LOCKED through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
    end
  end

  assign lk = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // State register
  // Also registers the outputs, which are decoded from state_d. As a result
  // the outputs change on the same edge as the state.
  // ---------------------------------------------------------------------------
  // Update state, timer, retry count and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRstMmcm;
      timer_q    <= '0;
      retry_q    <= '0;
      mmcm_rst_q <= 1'b1;
      clk_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      mmcm_rst_q <= mmcm_rst_d;
      clk_rst_q  <= clk_rst_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  assign retry_inc = retry_q + 3'd1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // One shared 17-bit timer serves the reset pulse, the lock timeout and the
  // stability window. It restarts from zero on every state change.
  // ---------------------------------------------------------------------------
  // Compute next state, next timer value and next retry count.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 17'd1;
    retry_d = retry_q;

    unique case (state_q)
      StRstMmcm: begin
        if (timer_q == RstLast) begin
          state_d = StWaitLock;
        end
      end

      StWaitLock: begin
        // Lock takes priority over a timeout in the same cycle.
        if (lk) begin
          state_d = StStabilize;
        end else if (timer_q == TimeoutLast) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RetryMax) ? StFault : StRstMmcm;
        end
      end

      StStabilize: begin
        // A dropout here is a glitch rather than a failed attempt, so
        // retry_cnt is left unchanged.
        if (!lk) begin
          state_d = StWaitLock;
        end else if (timer_q == StableLast) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (!lk) begin
          state_d = StLost;
        end
      end

      StLost: begin
        state_d = StRstMmcm;
      end

      StFault: begin
        // Terminal state: only rst_n leaves it, and lk is ignored.
        state_d = StFault;
      end

      default: begin
        state_d = StRstMmcm;
      end
    endcase

    // Reaching a stable lock ends the current sequence.
    if (state_d == StRun) begin
      retry_d = '0;
    end

    // Restart the timer on every state change. In states that never use it,
    // hold it at zero so it does not toggle.
    if (state_d != state_q ||
        state_q == StRun || state_q == StLost || state_q == StFault) begin
      timer_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // Outputs are decoded from the next state. clk_rst is low only in RUN, and
  // ready is high only in RUN. They are always complements of each other, so
  // ready falls on exactly the edge where clk_rst rises.
  // ---------------------------------------------------------------------------
  // Decode the registered outputs from the next state.
  always_comb begin
    mmcm_rst_d = 1'b0;
    clk_rst_d  = 1'b1;
    ready_d    = 1'b0;
    fault_d    = 1'b0;

    unique case (state_d)
      StRstMmcm: begin
        mmcm_rst_d = 1'b1;
      end

      StRun: begin
        clk_rst_d = 1'b0;
        ready_d   = 1'b1;
      end

      StFault: begin
        // Hold the MMCM in reset while the sequencer is faulted.
        mmcm_rst_d = 1'b1;
        fault_d    = 1'b1;
      end

      default: begin
        mmcm_rst_d = 1'b0;
      end
    endcase
  end

  assign mmcm_rst  = mmcm_rst_q;
  assign clk_rst   = clk_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

  // ---------------------------------------------------------------------------
  // Optional lock-loss counter
  // ---------------------------------------------------------------------------
`ifdef ULTRASOUND_CLK_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;

  // Count entries into LOST, saturating at 255. Only rst_n clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
    end else if (state_d == StLost && loss_cnt_q != 8'hff) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ultrasound_clk_lock_sequencer.sv
// Testbench for ultrasound_clk_lock_sequencer.
// The stimulus process queues every expected change of the DUT outputs, with
// the cycle at which it must occur, counted from rst_n release. A separate
// monitor compares each observed output change against the head of that queue.
// LOCK_TIMEOUT and STABLE_CYCLES are reduced to 64 to keep the run short.

module tb_ultrasound_clk_lock_sequencer;

  localparam int unsigned Sync    = 2;
  localparam int unsigned RstCyc  = 16;
  localparam int unsigned Timeout = 64;
  localparam int unsigned Stable  = 64;
  localparam int unsigned MaxRtry = 7;
  localparam int          LossReps = 258;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       locked_in = 1'b0;
  logic       mmcm_rst, clk_rst, ready, fault;
  logic [2:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  ultrasound_clk_lock_sequencer #(
    .SYNC_STAGES  (Sync),
    .RST_CYCLES   (RstCyc),
    .LOCK_TIMEOUT (Timeout),
    .STABLE_CYCLES(Stable),
    .MAX_RETRY    (MaxRtry)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .locked_in    (locked_in),
    .mmcm_rst     (mmcm_rst),
    .clk_rst      (clk_rst),
    .ready        (ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mmcm;
    logic       crst;
    logic       rdy;
    logic       flt;
    logic [2:0] rc;
    logic [7:0] llc;
  } outs_t;

  // Posedges since the last rst_n release.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  outs_t exp_val_q[$];
  int    exp_cyc_q[$];
  string exp_name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    losses = 0;

  function automatic logic [7:0] llc_exp(input int n);
`ifdef ULTRASOUND_CLK_LOCK_LOSS_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return (n > 0) ? 8'd0 : 8'd0;
`endif
  endfunction

  task automatic push(input string nm, input int c, input logic m, input logic cr,
                      input logic rd, input logic f, input logic [2:0] r,
                      input logic [7:0] l);
    outs_t o;
    o.mmcm = m; o.crst = cr; o.rdy = rd; o.flt = f; o.rc = r; o.llc = l;
    exp_val_q.push_back(o);
    exp_cyc_q.push_back(c);
    exp_name_q.push_back(nm);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: sample just after each negedge and after any rst_n fall, and
  // compare every change of the output vector with the next expected entry.
  initial begin
    outs_t cur, prev, e;
    int    ec;
    string en;
    bit    have_prev;
    have_prev = 1'b0;
    prev = '0;
    #3;
    forever begin
      cur = {mmcm_rst, clk_rst, ready, fault, retry_cnt, lock_loss_cnt};
      if (!have_prev || cur != prev) begin
        have_prev = 1'b1;
        prev = cur;
        n_cmp++;
        if (exp_val_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: got cyc=%0d mmcm_rst=%b clk_rst=%b ready=%b fault=%b retry=%0d llc=%0d, required no change",
                   cyc, cur.mmcm, cur.crst, cur.rdy, cur.flt, cur.rc, cur.llc);
        end else begin
          e  = exp_val_q.pop_front();
          ec = exp_cyc_q.pop_front();
          en = exp_name_q.pop_front();
          if (cur !== e || (ec >= 0 && cyc != ec)) begin
            n_bad++;
            $display("FAIL %s: got cyc=%0d mmcm_rst=%b clk_rst=%b ready=%b fault=%b retry=%0d llc=%0d, required cyc=%0d mmcm_rst=%b clk_rst=%b ready=%b fault=%b retry=%0d llc=%0d",
                     en, cyc, cur.mmcm, cur.crst, cur.rdy, cur.flt, cur.rc, cur.llc,
                     ec, e.mmcm, e.crst, e.rdy, e.flt, e.rc, e.llc);
          end
        end
      end
      @(negedge clk or negedge rst_n);
      #1;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of stimulus, required finish before time limit");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int b, w, t, g, run_c;

    // Power-on reset.
    #2;
    push("reset_values", -1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Normal bring-up: lock arrives 30 cycles after mmcm_rst falls.
    push("mmcm_rst_fall", RstCyc, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    push("bringup_ready", RstCyc + 30 + Sync + 1 + Stable,
         1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
    wait_cyc(RstCyc + 30);
    locked_in = 1'b1;
    wait_cyc(RstCyc + 30 + Sync + 1 + Stable + 5);

    // Repeated lock loss in RUN (3-cycle dropout), enough to saturate the count.
    for (int i = 0; i < LossReps; i++) begin
      b = cyc;
      losses++;
      push("loss_lost",   b + Sync + 1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, llc_exp(losses));
      push("loss_rst",    b + Sync + 2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, llc_exp(losses));
      push("loss_wait",   b + Sync + 2 + RstCyc, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, llc_exp(losses));
      push("loss_ready",  b + Sync + 3 + RstCyc + Stable,
           1'b0, 1'b0, 1'b1, 1'b0, 3'd0, llc_exp(losses));
      locked_in = 1'b0;
      wait_cyc(b + 3);
      locked_in = 1'b1;
      wait_cyc(b + Sync + 3 + RstCyc + Stable + 2);
    end

    // Lock loss, then a 1-cycle glitch 30 cycles into STABILIZE.
    b = cyc;
    losses++;
    g = b + Sync + 3 + RstCyc + 30;
    push("glitch_lost", b + Sync + 1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, llc_exp(losses));
    push("glitch_rst",  b + Sync + 2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, llc_exp(losses));
    push("glitch_wait", b + Sync + 2 + RstCyc, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, llc_exp(losses));
    push("glitch_ready", g + Sync + 2 + Stable, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, llc_exp(losses));
    locked_in = 1'b0;
    wait_cyc(b + 3);
    locked_in = 1'b1;
    wait_cyc(g);
    locked_in = 1'b0;
    wait_cyc(g + 1);
    locked_in = 1'b1;
    wait_cyc(g + Sync + 2 + Stable + 3);

    // Lock lost for good: timeouts, retries 1..6, then FAULT on the 7th.
    b = cyc;
    losses++;
    push("to_lost", b + Sync + 1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, llc_exp(losses));
    push("to_rst",  b + Sync + 2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, llc_exp(losses));
    w = b + Sync + 2 + RstCyc;
    push("to_wait0", w, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, llc_exp(losses));
    for (int k = 1; k < MaxRtry; k++) begin
      t = w + Timeout;
      push("to_retry_rst", t, 1'b1, 1'b1, 1'b0, 1'b0, 3'(k), llc_exp(losses));
      w = t + RstCyc;
      push("to_retry_wait", w, 1'b0, 1'b1, 1'b0, 1'b0, 3'(k), llc_exp(losses));
    end
    t = w + Timeout;
    push("to_fault", t, 1'b1, 1'b1, 1'b0, 1'b1, 3'(MaxRtry), llc_exp(losses));
    locked_in = 1'b0;
    wait_cyc(t + 5);
    // A lock arriving in FAULT must be ignored.
    locked_in = 1'b1;
    wait_cyc(t + 100);

    // Asynchronous reset in FAULT, applied between clock edges.
    losses = 0;
    @(negedge clk);
    #2;
    push("fault_async_reset", -1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Bring-up with lock already present, interrupted mid-STABILIZE.
    push("re_mmcm_fall", RstCyc, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    wait_cyc(RstCyc + 1 + 20);
    #2;
    push("stab_async_reset", -1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Final clean bring-up.
    run_c = RstCyc + 1 + Stable;
    push("final_mmcm_fall", RstCyc, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    push("final_ready", run_c, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
    wait_cyc(run_c + 10);
    @(negedge clk);
    #2;

    n_cmp++;
    if (exp_val_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_expectations: got %0d unobserved (next %s), required 0",
               exp_val_q.size(), exp_name_q[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
